stream_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one valid/ready stream sink (e.g. the memory-capturing test sink) between PORTS requester streams.
- Grants one requester at a time for a burst of up to BEAT_LEN beats, then rotates.
- Forwards the granted beats through a one-deep registered output stage.
- Sits between multiple producer pipelines and a single downstream consumer in the test and datapath harnesses.

---
 rtl/stream_rr_arbiter.sv | 103 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter sharing one registered valid/ready sink between PORTS streams.
// Define STREAM_RR_ARB_SRC_TAG_EN to add the oSrc_BM source-index tag output.
module stream_rr_arbiter #(
    parameter int PORTS    = 4,
    parameter int WIDTH    = 8,
    parameter int BEAT_LEN = 16
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [PORTS-1:0]         iValid_AM,
    output logic [PORTS-1:0]         oReady_AM,
    input  logic [PORTS*WIDTH-1:0]   iData_AM,
    output logic                     oValid_BM,
    input  logic                     iReady_BM,
    output logic [WIDTH-1:0]         oData_BM,
    output logic [PORTS-1:0]         oGrant
`ifdef STREAM_RR_ARB_SRC_TAG_EN
    ,
    output logic [$clog2(PORTS)-1:0] oSrc_BM
`endif
);
    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(BEAT_LEN + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   owner, owner_nx, last, last_nx, idx;
    logic [CW-1:0]   count, count_nx;
    logic            out_free, accept, owner_valid;
    logic [WIDTH-1:0] owner_data;

    always_comb begin
        out_free    = !oValid_BM || iReady_BM;
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < PORTS; k++) begin
            oGrant[k]    = (state == OWN) && (owner == PW'(k));
            oReady_AM[k] = oGrant[k] && out_free;
            if (owner == PW'(k)) begin
                owner_valid = iValid_AM[k];
                owner_data  = iData_AM[k*WIDTH +: WIDTH];
            end
        end
        accept = (state == OWN) && owner_valid && out_free;
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        count_nx = count;
        idx      = '0;
        if (state == IDLE) begin
            // Walk offsets from farthest to nearest so the nearest requester after last wins.
            for (int i = PORTS - 1; i >= 0; i--) begin
                idx = PW'((int'(last) + 1 + i) % PORTS);
                if (iValid_AM[idx]) begin
                    state_nx = OWN;
                    owner_nx = idx;
                end
            end
            count_nx = '0;
        end else if (accept && count == CW'(BEAT_LEN - 1)) begin
            state_nx = IDLE;
            last_nx  = owner;
            count_nx = '0;
        end else if (accept) begin
            count_nx = count + 1'b1;
        end else if (out_free && !owner_valid) begin
            state_nx = IDLE;
            last_nx  = owner;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= PW'(PORTS - 1);
            count     <= '0;
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
`ifdef STREAM_RR_ARB_SRC_TAG_EN
            oSrc_BM   <= '0;
`endif
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            count <= count_nx;
            if (accept) begin
                oValid_BM <= 1'b1;
                oData_BM  <= owner_data;
`ifdef STREAM_RR_ARB_SRC_TAG_EN
                oSrc_BM   <= owner;
`endif
            end else if (iReady_BM) begin
                oValid_BM <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for stream_rr_arbiter with BEAT_LEN 2, 16 and 4 instances.
module tb_stream_rr_arbiter;
    logic       clk = 1'b0;
    logic       rstn [3];
    logic [3:0] vin  [3];
    logic [31:0] din [3];
    logic [3:0] rdy  [3];
    logic       ov   [3];
    logic       ir   [3];
    logic [7:0] od   [3];
    logic [3:0] gnt  [3];
`ifdef STREAM_RR_ARB_SRC_TAG_EN
    logic [1:0] src  [3];
`endif
    logic [3:0] fire [3];
    logic [7:0] sq [12][$];
    logic [9:0] exp_q [3][$];
    logic [9:0] e;
    int         t4 [$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       found;
    logic [3:0] g1 [12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                            4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        stream_rr_arbiter #(.PORTS(4), .WIDTH(8), .BEAT_LEN(d == 0 ? 2 : (d == 1 ? 16 : 4))) u_dut (
            .iCLK(clk), .iRST(rstn[d]), .iValid_AM(vin[d]), .oReady_AM(rdy[d]), .iData_AM(din[d]),
            .oValid_BM(ov[d]), .iReady_BM(ir[d]), .oData_BM(od[d]), .oGrant(gnt[d])
`ifdef STREAM_RR_ARB_SRC_TAG_EN
            , .oSrc_BM(src[d])
`endif
        );
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    task automatic push(input int d, input int k, input logic [7:0] b, input logic keep);
        sq[d*4+k].push_back(b);
        if (keep) exp_q[d].push_back({2'(k), b});
    endtask

    task automatic wait_empty(input int d);
        for (int i = 0; i < 300 && exp_q[d].size() != 0; i++) @(negedge clk);
        chk($sformatf("drain dut%0d", d), exp_q[d].size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Sources: each requester presents the head of its queue and pops it after a handshake.
    always @(clk) begin
        #1;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 4; k++) begin
                if (clk && fire[d][k] && sq[d*4+k].size() != 0) void'(sq[d*4+k].pop_front());
                vin[d][k] = sq[d*4+k].size() != 0;
                din[d][k*8 +: 8] = sq[d*4+k].size() != 0 ? sq[d*4+k][0] : 8'h00;
            end
    end

    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 3; d++) begin
            fire[d] = vin[d] & rdy[d];
            if (ov[d] && ir[d]) begin
                if (d == 2) t4.push_back(cyc);
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat dut%0d: got unexpected %0h expected none", d, od[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("data dut%0d", d), od[d], e[7:0]);
`ifdef STREAM_RR_ARB_SRC_TAG_EN
                    chk($sformatf("src dut%0d", d), src[d], e[9:8]);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0;
            ir[d]   = 1'b1;
            fire[d] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst valid dut%0d", d), ov[d], 0);
            chk($sformatf("rst data dut%0d", d), od[d], 0);
            chk($sformatf("rst grant dut%0d", d), gnt[d], 0);
            chk($sformatf("rst ready dut%0d", d), rdy[d], 0);
            rstn[d] = 1'b1;
        end
        @(negedge clk);

        // Priority after reset, BEAT_LEN=2: two beats per port in port order.
        for (int k = 0; k < 4; k++) begin
            push(0, k, 8'((k + 1) * 16), 1'b1);
            push(0, k, 8'((k + 1) * 16 + 1), 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #3 chk($sformatf("t1 grant %0d", i), gnt[0], g1[i]);
        end
        wait_empty(0);

        // Backpressure on port 1 after the second beat.
        for (int b = 1; b <= 5; b++) push(1, 1, 8'(b), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = ov[1] && od[1] == 8'h02;
        end
        chk("t2 reach beat2", found, 1);
        ir[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            chk("t2 hold data", od[1], 8'h02);
            chk("t2 hold valid", ov[1], 1);
            chk("t2 ready low", rdy[1][1], 0);
            chk("t2 grant kept", gnt[1], 4'b0010);
        end
        @(negedge clk);
        ir[1] = 1'b1;
        wait_empty(1);

        // Early release by port 2 while port 0 waits; pointer 1 so port 2 wins first.
        for (int b = 0; b < 3; b++) push(1, 2, 8'hA0 + 8'(b), 1'b1);
        push(1, 0, 8'h50, 1'b1);
        push(1, 0, 8'h51, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = gnt[1] == 4'b0100;
        end
        chk("t3 grant port2", found, 1);
        for (int i = 0; i < 20 && gnt[1] == 4'b0100; i++) @(negedge clk);
        chk("t3 idle gap", gnt[1], 4'b0000);
        @(negedge clk);
        chk("t3 grant port0", gnt[1], 4'b0001);
        wait_empty(1);

        // Burst limit BEAT_LEN=4 with ports 0 and 3 always valid.
        t4.delete();
        for (int b = 0; b < 8; b++) sq[2*4+0].push_back(8'(b));
        for (int b = 0; b < 8; b++) sq[2*4+3].push_back(8'h30 + 8'(b));
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 4; b++) exp_q[2].push_back({2'd0, 8'(r * 4 + b)});
            for (int b = 0; b < 4; b++) exp_q[2].push_back({2'd3, 8'h30 + 8'(r * 4 + b)});
        end
        wait_empty(2);
        chk("t4 beat count", t4.size(), 16);
        if (t4.size() >= 16) begin
            chk("t4 run throughput", t4[3] - t4[0], 3);
            for (int k = 1; k < 4; k++) chk($sformatf("t4 period %0d", k), t4[4*k] - t4[4*k-4], 5);
        end

        // Reset while a beat sits stalled in the output register.
        ir[2] = 1'b0;
        push(2, 1, 8'h77, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = ov[2];
        end
        chk("t5 stalled beat", found, 1);
        rstn[2] = 1'b0;
        @(negedge clk);
        #3;
        chk("t5 valid cleared", ov[2], 0);
        chk("t5 grant cleared", gnt[2], 0);
        chk("t5 ready cleared", rdy[2], 0);
        rstn[2] = 1'b1;
        ir[2]   = 1'b1;
        push(2, 0, 8'hE0, 1'b1);
        push(2, 1, 8'hE1, 1'b1);
        for (int i = 0; i < 20 && gnt[2] == 4'b0000; i++) @(negedge clk);
        chk("t5 first priority", gnt[2], 4'b0001);
        wait_empty(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
